// File: rtl/rotary_pulse_gen.sv
// Purpose: rotary encoder front end: sync + debounce A/B/D, quadrature detent FSM, one-cycle L/R/D pulses.
// Latency: raw edge -> pulse is 2 (sync) + DEB_CYC (debounce) + 1 (registered pulse) clk cycles, +/-1 for sampling.
// Backpressure: none; pulses are fire-and-forget and the consumer must sample every cycle.
// Build option: define ROTARY_KEY_EN to compile in the push-switch (key_d -> D_pulse) path; otherwise D_pulse is 0.
module rotary_pulse_gen #(
    parameter int DEB_CYC = 24000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_a,
    input  logic key_b,
    input  logic key_d,
    output logic L_pulse,
    output logic R_pulse,
    output logic D_pulse
);

    // A counter that reaches DEB_CYC-1 never needs more than $clog2(DEB_CYC) bits,
    // and the accept compare clears it before it could wrap.
    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    // Channel bit order: 0 = A, 1 = B, 2 = D (only when the key path is present).
`ifdef ROTARY_KEY_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif

    logic [NCH-1:0] raw_in;
    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] filt_q;
    logic [CNT_W-1:0] deb_cnt_q [NCH];

`ifdef ROTARY_KEY_EN
    assign raw_in = {key_d, key_b, key_a};
`else
    assign raw_in = {key_b, key_a};
    // Push switch is not used in this build; keep the port for a stable pinout.
    logic unused_key_d;
    assign unused_key_d = key_d;
`endif

    // Two-flop synchronizers; idle-high inputs so they reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce: a new level must persist for DEB_CYC consecutive cycles;
    // any return to the filtered level restarts the count, so short glitches are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '1;
            for (int i = 0; i < NCH; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == CNT_LAST) begin
                    filt_q[i]    <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Quadrature tracker. A detent is 11 -> 10 -> 00 -> 01 -> 11 (clockwise) or the
    // mirror with 10/01 swapped (counter-clockwise). Backtracking one step is allowed;
    // anything else abandons the detent without a pulse.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CW1  = 3'd1,
        ST_CW2  = 3'd2,
        ST_CW3  = 3'd3,
        ST_CCW1 = 3'd4,
        ST_CCW2 = 3'd5,
        ST_CCW3 = 3'd6
    } quad_state_t;

    quad_state_t state_q;
    quad_state_t state_nxt;
    logic        r_evt;
    logic        l_evt;
    logic [1:0]  ab;

    assign ab = {filt_q[0], filt_q[1]};

    // State register; reset drops any partially walked detent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and detent-complete events from the filtered AB pair.
    always_comb begin
        state_nxt = state_q;
        r_evt     = 1'b0;
        l_evt     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ab == 2'b10)      state_nxt = ST_CW1;
                else if (ab == 2'b01) state_nxt = ST_CCW1;
                else                  state_nxt = ST_IDLE;
            end
            ST_CW1: begin
                if (ab == 2'b00)      state_nxt = ST_CW2;
                else if (ab == 2'b10) state_nxt = ST_CW1;
                else                  state_nxt = ST_IDLE;
            end
            ST_CW2: begin
                if (ab == 2'b01)      state_nxt = ST_CW3;
                else if (ab == 2'b10) state_nxt = ST_CW1;
                else if (ab == 2'b00) state_nxt = ST_CW2;
                else                  state_nxt = ST_IDLE;
            end
            ST_CW3: begin
                if (ab == 2'b11) begin
                    state_nxt = ST_IDLE;
                    r_evt     = 1'b1;
                end
                else if (ab == 2'b00) state_nxt = ST_CW2;
                else if (ab == 2'b01) state_nxt = ST_CW3;
                else                  state_nxt = ST_IDLE;
            end
            ST_CCW1: begin
                if (ab == 2'b00)      state_nxt = ST_CCW2;
                else if (ab == 2'b01) state_nxt = ST_CCW1;
                else                  state_nxt = ST_IDLE;
            end
            ST_CCW2: begin
                if (ab == 2'b10)      state_nxt = ST_CCW3;
                else if (ab == 2'b01) state_nxt = ST_CCW1;
                else if (ab == 2'b00) state_nxt = ST_CCW2;
                else                  state_nxt = ST_IDLE;
            end
            ST_CCW3: begin
                if (ab == 2'b11) begin
                    state_nxt = ST_IDLE;
                    l_evt     = 1'b1;
                end
                else if (ab == 2'b00) state_nxt = ST_CCW2;
                else if (ab == 2'b10) state_nxt = ST_CCW3;
                else                  state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered detent pulses; the FSM can only complete one direction per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R_pulse <= 1'b0;
            L_pulse <= 1'b0;
        end else begin
            R_pulse <= r_evt;
            L_pulse <= l_evt;
        end
    end

`ifdef ROTARY_KEY_EN
    logic d_prev_q;

    // Press detect on the filtered switch: one pulse on 1 -> 0, nothing on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_prev_q <= 1'b1;
            D_pulse  <= 1'b0;
        end else begin
            d_prev_q <= filt_q[2];
            D_pulse  <= d_prev_q & ~filt_q[2];
        end
    end
`else
    assign D_pulse = 1'b0;
`endif

endmodule
